// File: rtl/switch_port_ingress.sv
//------------------------------------------------------------------------------
// Module   : switch_port_ingress
// Brief    : Ingress FIFO for one switch port, with a serve FSM that requests
//            the crossbar per target.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module switch_port_ingress #(
  parameter int PORT_ID = 0,
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [3:0]        source_in,
  input  logic [3:0]        target_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic [3:0]        req_out,
  input  logic [3:0]        gnt_in,
  output logic [3:0]        source_out,
  output logic [DATA_W-1:0] data_out,
  output logic [7:0]        drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] c_depth   = CNT_W'(DEPTH);
  localparam logic [3:0]       c_own_src = 4'(1 << PORT_ID);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_src_mem  [DEPTH];
  logic [3:0]        r_tgt_mem  [DEPTH];
  logic [DATA_W-1:0] r_data_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [3:0]        r_rem;
  logic [3:0]        w_rem_nxt;
  logic [3:0]        w_rem_left;
  logic [7:0]        r_drop;
  logic              w_ready;
  logic              w_accept;
  logic              w_legal;
  logic              w_push;
  logic              w_drop;
  logic              w_pop;
  logic              w_nonempty;
  logic [3:0]        w_req;

  assign w_ready    = (r_count < c_depth);
  assign w_accept   = valid_in & w_ready;
  assign w_legal    = (target_in != 4'b0000) && (source_in == c_own_src);
  assign w_push     = w_accept & w_legal;
  assign w_drop     = w_accept & ~w_legal;
  assign w_nonempty = (r_count != '0);
  assign w_rem_left = r_rem & ~gnt_in;

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_pop       = 1'b0;
    w_req       = 4'b0000;
    case (r_state)
      ST_IDLE: begin
        if (w_nonempty) begin
          w_state_nxt = ST_SERVE;
          w_rem_nxt   = r_tgt_mem[r_rd_ptr];
        end
      end
      ST_SERVE: begin
        w_req     = r_rem;
        w_rem_nxt = w_rem_left;
        if (w_rem_left == 4'b0000) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_rem    <= 4'b0000;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_drop   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
    end
  end

  // Payload storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_src_mem[r_wr_ptr]  <= source_in;
      r_tgt_mem[r_wr_ptr]  <= target_in;
      r_data_mem[r_wr_ptr] <= data_in;
    end
  end

  assign ready      = w_ready;
  assign req_out    = w_req;
  assign source_out = w_nonempty ? r_src_mem[r_rd_ptr]  : 4'b0000;
  assign data_out   = w_nonempty ? r_data_mem[r_rd_ptr] : '0;
  assign drop_cnt   = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_switch_port_ingress.sv
//------------------------------------------------------------------------------
// Module   : tb_switch_port_ingress
// Brief    : Self-checking bench: directed vector table, corner sequences and
//            randomized traffic against a queue-based reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_switch_port_ingress;

  localparam int PORT_ID = 0;
  localparam int DEPTH   = 4;
  localparam int DATA_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              valid_in;
  logic [3:0]        source_in;
  logic [3:0]        target_in;
  logic [DATA_W-1:0] data_in;
  logic              ready;
  logic [3:0]        req_out;
  logic [3:0]        gnt_in;
  logic [3:0]        source_out;
  logic [DATA_W-1:0] data_out;
  logic [7:0]        drop_cnt;

  switch_port_ingress #(.PORT_ID(PORT_ID), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .source_in  (source_in),
    .target_in  (target_in),
    .data_in    (data_in),
    .ready      (ready),
    .req_out    (req_out),
    .gnt_in     (gnt_in),
    .source_out (source_out),
    .data_out   (data_out),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       v;
    logic [3:0] src;
    logic [3:0] tgt;
    logic [7:0] data;
    logic [3:0] gnt;
    logic       e_ready;
    logic [3:0] e_req;
    logic [3:0] e_src;
    logic [7:0] e_data;
    logic [7:0] e_drop;
  } vec_t;

  typedef struct {
    logic [3:0] src;
    logic [3:0] tgt;
    logic [7:0] data;
  } pkt_t;

  vec_t       vecs [10];
  pkt_t       q [$];
  bit         m_serving;
  logic [3:0] m_rem;
  int         m_drop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic er, input logic [3:0] ereq,
                         input logic [3:0] esrc, input logic [7:0] edata, input logic [7:0] edrop);
    chk($sformatf("%s.ready", tag), 32'(ready), 32'(er));
    chk($sformatf("%s.req", tag), 32'(req_out), 32'(ereq));
    chk($sformatf("%s.src", tag), 32'(source_out), 32'(esrc));
    chk($sformatf("%s.data", tag), 32'(data_out), 32'(edata));
    chk($sformatf("%s.drop", tag), 32'(drop_cnt), 32'(edrop));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance one edge and retire the offered packet if it was taken.
  task automatic advance();
    logic acc;
    acc = valid_in && ready;
    step();
    if (acc) valid_in = 1'b0;
  endtask

  task automatic idle_inputs();
    valid_in = 1'b0; source_in = 4'b0; target_in = 4'b0; data_in = '0; gnt_in = 4'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic offer(input logic [3:0] s, input logic [3:0] t, input logic [7:0] d);
    valid_in = 1'b1; source_in = s; target_in = t; data_in = d;
  endtask

  // Grants every head fully and expects n packets carrying consecutive data.
  task automatic drain(input string tag, input int n, input logic [7:0] first);
    for (int k = 0; k < n; k++) begin
      int w;
      w = 0;
      while (req_out == 4'b0 && w < 12) begin
        advance();
        w++;
      end
      chk($sformatf("%s.req_seen%0d", tag, k), 32'(req_out != 4'b0), 32'd1);
      chk($sformatf("%s.data%0d", tag, k), 32'(data_out), 32'(first + 8'(k)));
      chk($sformatf("%s.src%0d", tag, k), 32'(source_out), 32'(4'b0001));
      gnt_in = req_out;
      advance();
      gnt_in = 4'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic req_seen;

    //            v     src      tgt      data   gnt      rdy   req      src      data   drop
    vecs[0] = '{1'b1, 4'b0001, 4'b0100, 8'hA5, 4'b1111, 1'b1, 4'b0000, 4'b0001, 8'hA5, 8'd0};
    vecs[1] = '{1'b0, 4'b0000, 4'b0000, 8'h00, 4'b1111, 1'b1, 4'b0100, 4'b0001, 8'hA5, 8'd0};
    vecs[2] = '{1'b0, 4'b0000, 4'b0000, 8'h00, 4'b1111, 1'b1, 4'b0000, 4'b0000, 8'h00, 8'd0};
    vecs[3] = '{1'b1, 4'b0001, 4'b1011, 8'h3C, 4'b0000, 1'b1, 4'b0000, 4'b0001, 8'h3C, 8'd0};
    vecs[4] = '{1'b0, 4'b0000, 4'b0000, 8'h00, 4'b0001, 1'b1, 4'b1011, 4'b0001, 8'h3C, 8'd0};
    vecs[5] = '{1'b0, 4'b0000, 4'b0000, 8'h00, 4'b0101, 1'b1, 4'b1010, 4'b0001, 8'h3C, 8'd0};
    vecs[6] = '{1'b0, 4'b0000, 4'b0000, 8'h00, 4'b1010, 1'b1, 4'b0000, 4'b0000, 8'h00, 8'd0};
    vecs[7] = '{1'b1, 4'b0001, 4'b0000, 8'h11, 4'b0000, 1'b1, 4'b0000, 4'b0000, 8'h00, 8'd1};
    vecs[8] = '{1'b1, 4'b0010, 4'b0001, 8'h22, 4'b0000, 1'b1, 4'b0000, 4'b0000, 8'h00, 8'd2};
    vecs[9] = '{1'b0, 4'b0000, 4'b0000, 8'h00, 4'b0000, 1'b1, 4'b0000, 4'b0000, 8'h00, 8'd2};

    // Reset state, visible while rst_n is still low
    idle_inputs();
    rst_n = 1'b0;
    #3;
    chk_out("reset", 1'b1, 4'b0, 4'b0, 8'h00, 8'd0);
    do_reset();

    for (int i = 0; i < 10; i++) begin
      valid_in = vecs[i].v; source_in = vecs[i].src; target_in = vecs[i].tgt;
      data_in = vecs[i].data; gnt_in = vecs[i].gnt;
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_req,
              vecs[i].e_src, vecs[i].e_data, vecs[i].e_drop);
    end
    idle_inputs();

    // Drop counter saturation
    req_seen = 1'b0;
    offer(4'b0001, 4'b0000, 8'h99);
    for (int i = 0; i < 300; i++) begin
      step();
      req_seen |= (req_out != 4'b0);
    end
    idle_inputs();
    chk("sat.drop", 32'(drop_cnt), 32'd255);
    chk("sat.no_req", 32'(req_seen), 32'd0);

    // Full buffer and backpressure
    do_reset();
    chk("full.drop_cleared", 32'(drop_cnt), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      offer(4'b0001, 4'b0001, 8'(i));
      step();
    end
    chk("full.ready_low", 32'(ready), 32'd0);
    offer(4'b0001, 4'b0001, 8'd5);
    step();
    step();
    chk("full.held_ready", 32'(ready), 32'd0);
    chk("full.held_drop", 32'(drop_cnt), 32'd0);
    chk("full.head", 32'(data_out), 32'd1);
    drain("full", 5, 8'd1);
    step();
    chk_out("full.empty", 1'b1, 4'b0, 4'b0, 8'h00, 8'd0);

    // Push and pop on the same edge at count 2
    do_reset();
    offer(4'b0001, 4'b0001, 8'h61); step();
    offer(4'b0001, 4'b0001, 8'h62); step();
    chk("pp.req_a", 32'(req_out), 32'(4'b0001));
    offer(4'b0001, 4'b0001, 8'h63); gnt_in = 4'b0001; step();
    gnt_in = 4'b0;
    chk("pp.ready", 32'(ready), 32'd1);
    chk("pp.head_b", 32'(data_out), 32'h62);
    offer(4'b0001, 4'b0001, 8'h64); step();
    chk("pp.count3_ready", 32'(ready), 32'd1);
    offer(4'b0001, 4'b0001, 8'h65); step();
    chk("pp.count4_ready", 32'(ready), 32'd0);
    valid_in = 1'b0;
    drain("pp", 4, 8'h62);

    // Reset in the middle of SERVE
    offer(4'b0100, 4'b0001, 8'h70); step();
    offer(4'b0001, 4'b0011, 8'h71); step();
    valid_in = 1'b0;
    step();
    chk("mid.serving", 32'(req_out), 32'(4'b0011));
    chk("mid.drop_before", 32'(drop_cnt), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("mid.in_reset", 1'b1, 4'b0, 4'b0, 8'h00, 8'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    chk_out("mid.released", 1'b1, 4'b0, 4'b0, 8'h00, 8'd0);
    offer(4'b0001, 4'b0010, 8'h77); step();
    valid_in = 1'b0;
    chk("rel.first_accept", 32'(data_out), 32'h77);
    step();
    chk("rel.req", 32'(req_out), 32'(4'b0010));

    // Randomized traffic against the reference model
    do_reset();
    q.delete();
    m_serving = 1'b0;
    m_rem     = 4'b0;
    m_drop    = 0;
    for (int c = 0; c < 1500; c++) begin
      int  sz;
      bit  pop, acc, legal;
      valid_in  = 1'($urandom_range(0, 1));
      source_in = ($urandom_range(0, 3) != 0) ? 4'b0001 : 4'($urandom);
      target_in = 4'($urandom);
      data_in   = 8'($urandom);
      gnt_in    = 4'($urandom);

      sz    = q.size();
      pop   = m_serving && ((m_rem & ~gnt_in) == 4'b0);
      acc   = valid_in && (sz < DEPTH);
      legal = (target_in != 4'b0) && (source_in == 4'(1 << PORT_ID));
      if (m_serving) begin
        m_rem = m_rem & ~gnt_in;
        if (pop) begin
          void'(q.pop_front());
          m_serving = 1'b0;
        end
      end else if (sz > 0) begin
        m_serving = 1'b1;
        m_rem     = q[0].tgt;
      end
      if (acc) begin
        if (legal) q.push_back('{source_in, target_in, data_in});
        else if (m_drop < 255) m_drop++;
      end

      step();
      chk_out($sformatf("rnd%0d", c), q.size() < DEPTH,
              m_serving ? m_rem : 4'b0,
              (q.size() > 0) ? q[0].src : 4'b0,
              (q.size() > 0) ? q[0].data : 8'h00,
              8'(m_drop));
    end
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/switch_port_ingress.md
SWITCH_PORT_INGRESS -- requirements
Module: switch_port_ingress

Interface
REQ-001 Parameter PORT_ID, default 0, index (0..3) of the switch port this ingress stage serves.
REQ-002 Parameter DEPTH, default 4, packet buffer depth in entries, power of two, minimum 2.
REQ-003 Parameter DATA_W, default 8, payload width in bits.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 valid_in  input  1  upstream packet valid.
REQ-007 source_in  input  4  one-hot source port of the packet.
REQ-008 target_in  input  4  target port mask; multicast allowed.
REQ-009 data_in  input  DATA_W  packet payload.
REQ-010 ready  output  1  buffer can accept a packet this cycle.
REQ-011 req_out  output  4  per-target request toward the crossbar, one bit per output port.
REQ-012 gnt_in  input  4  per-target grant from the crossbar.
REQ-013 source_out  output  4  source field of the head packet being served.
REQ-014 data_out  output  DATA_W  payload of the head packet being served.
REQ-015 drop_cnt  output  8  count of dropped packets, saturating.

Function
REQ-016 Acceptance: a packet is taken at a rising edge when valid_in=1 and ready=1; no other condition qualifies it.
REQ-017 ready=1 when stored count < DEPTH; ready is decoded from registered count only and does not depend on valid_in or gnt_in.
REQ-018 Legality check: an accepted packet is legal when target_in!=0 and source_in equals one-hot (1<<PORT_ID).
REQ-019 Illegal accepted packet: not written; drop_cnt increments by 1, holding at 255.
REQ-020 Legal accepted packet: written at the write pointer; write pointer advances mod DEPTH; count increments.
REQ-021 Buffer order is strict FIFO; no reordering and no overwrite of stored entries.
REQ-022 Serve FSM states: IDLE, SERVE.
REQ-023 IDLE: req_out=0; if count>0 at an edge, load rem = head target, go to SERVE.
REQ-024 SERVE: req_out=rem; source_out and data_out hold the head entry, stable for the whole SERVE period.
REQ-025 SERVE grant rule: gnt bits outside rem are ignored; at each edge, rem <= rem & ~gnt_in.
REQ-026 SERVE completion: when (rem & ~gnt_in)==0 at an edge, the head is popped (read pointer +1 mod DEPTH, count -1) and the FSM goes to IDLE.
REQ-027 Partial grants: multicast bits are delivered over any number of cycles; granted bits are never re-requested.
REQ-028 Latency: a legal packet accepted at edge E into an empty buffer with FSM in IDLE drives req_out from edge E+1.
REQ-029 Back-to-back: after a pop, the next head is requested one cycle later (one IDLE bubble per packet).
REQ-030 Simultaneous push and pop in one edge: count is unchanged, both pointers advance; allowed only when ready=1 (count<DEPTH).
REQ-031 Full: with count=DEPTH, ready=0; valid_in is ignored, and no write and no drop count occur.
REQ-032 Empty: in IDLE with count=0, source_out=0 and data_out=0.
REQ-033 gnt_in while in IDLE has no effect.

Reset
REQ-034 rst_n=0 immediately clears pointers, count, rem, the FSM (to IDLE) and drop_cnt, regardless of clk.
REQ-035 Output values during reset: ready=1, req_out=0, source_out=0, data_out=0, drop_cnt=0.
REQ-036 Reset mid-serve: all buffered packets are discarded with no pop, grant or drop recorded.
REQ-037 Release: the first acceptance is possible at the first rising edge after rst_n rises.

Verification
REQ-038 PORT_ID=0, gnt_in=4'b1111 held: send source=0001, target=0100, data=8'hA5. Required: req_out=0100 one cycle after accept, data_out=A5, popped next edge, req_out=0 after.
REQ-039 Multicast: target=1011, grant 0001 in cycle 1, then 1010 in cycle 2. Required: req_out goes 1011 -> 1010 -> 0000, with a single pop at the second grant.
REQ-040 Drops: send target=0000, then source=0010 (PORT_ID=0). Required: drop_cnt=2, count=0, req_out never asserted; drive 300 illegal packets and require drop_cnt=255.
REQ-041 Full/backpressure: gnt_in=0, send 5 legal packets. Required: ready=0 after 4 accepted; packet 5 held off; grant each head in turn, packets leave in order 1..5 with matching data.
REQ-042 Push and pop in the same edge at count=2. Required: count remains 2 and the order is preserved; then assert rst_n=0 in the middle of SERVE. Required: req_out=0 and ready=1 immediately, and drop_cnt=0.
